// File: rtl/rtttl_player_if.sv
// Song ROM read bus between the melody sequencer (master) and a synchronous ROM (slave).
// Read data is valid one clock after rom_en is sampled high.
interface rtttl_player_if #(
  parameter int ADDR_W = 8,
  parameter int DUR_W  = 6
);
  logic                 rom_en;
  logic [ADDR_W-1:0]    rom_addr;
  logic [8+DUR_W-1:0]   rom_data;

  modport master (
    output rom_en,
    output rom_addr,
    input  rom_data
  );

  modport slave (
    input  rom_en,
    input  rom_addr,
    output rom_data
  );
endinterface

// File: rtl/rtttl_player.sv
// Melody sequencer: walks an external song ROM and drives {octave, note} to a tone
// generator, holding each entry for its duration in 1/64-note prescaler ticks.
module rtttl_player #(
  parameter int TICK_DIV = 23810,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 62,
  parameter int DUR_W    = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic           stop_i,
  input  logic           pause_i,
  input  logic           loop_en_i,
  rtttl_player_if.master rom,
  output logic [3:0]     octave_o,
  output logic [3:0]     note_o,
  output logic           busy_o,
  output logic           note_stb_o,
  output logic           done_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [ADDR_W:0] END_ADDR  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAY
  } state_e;

  state_e            state_q;
  logic [PW-1:0]     presc_q;
  logic [DUR_W-1:0]  remaining_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rom_en_q;
  logic [3:0]        octave_q;
  logic [3:0]        note_q;
  logic              note_stb_q;
  logic              done_q;

  logic [DUR_W-1:0]  entry_dur;
  logic [3:0]        entry_oct;
  logic [3:0]        entry_note;
  logic [ADDR_W:0]   addr_d;
  logic              running;
  logic              tick;
  logic              note_over;
  logic              addr_last;
  logic              end_hit;
  logic              advance;

  assign entry_dur  = rom.rom_data[DUR_W-1:0];
  assign entry_note = rom.rom_data[DUR_W+3:DUR_W];
  assign entry_oct  = rom.rom_data[DUR_W+7:DUR_W+4];

  // The extra address bit lets addr+1 reach DEPTH even when DEPTH == 2**ADDR_W.
  assign addr_d    = {1'b0, addr_q} + (ADDR_W + 1)'(1);
  assign running   = (state_q != IDLE) && !pause_i;
  assign tick      = running && (presc_q == PRESC_MAX);
  assign note_over = (state_q == PLAY) && tick && (remaining_q == DUR_W'(1));
  assign addr_last = (addr_d == END_ADDR);
  assign end_hit   = ((state_q == LOAD) && (entry_dur == '0)) || (note_over && addr_last);
  assign advance   = note_over && !addr_last;

  // Prescaler free-runs across notes so note spacing stays exactly dur*TICK_DIV.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
      rom_en_q    <= 1'b0;
      octave_q    <= '0;
      note_q      <= '0;
      note_stb_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      note_stb_q <= 1'b0;
      done_q     <= 1'b0;
      rom_en_q   <= 1'b0;
      if (running) begin
        presc_q <= (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
      end

      if (stop_i && (state_q != IDLE)) begin
        state_q  <= IDLE;
        octave_q <= '0;
        note_q   <= '0;
      end else if (end_hit) begin
        // Restarting from an end marker at entry 0 would refetch it forever.
        if (loop_en_i && (addr_q != '0)) begin
          addr_q   <= '0;
          rom_en_q <= 1'b1;
          state_q  <= FETCH;
        end else begin
          state_q  <= IDLE;
          octave_q <= '0;
          note_q   <= '0;
          done_q   <= 1'b1;
        end
      end else if (advance) begin
        addr_q   <= addr_d[ADDR_W-1:0];
        rom_en_q <= 1'b1;
        state_q  <= FETCH;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i && !stop_i) begin
              presc_q  <= '0;
              addr_q   <= '0;
              rom_en_q <= 1'b1;
              state_q  <= FETCH;
            end
          end
          FETCH: begin
            state_q <= LOAD;
          end
          LOAD: begin
            octave_q    <= entry_oct;
            note_q      <= entry_note;
            remaining_q <= entry_dur;
            note_stb_q  <= 1'b1;
            state_q     <= PLAY;
          end
          PLAY: begin
            if (tick) begin
              remaining_q <= remaining_q - 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign rom.rom_en   = rom_en_q;
  assign rom.rom_addr = addr_q;
  assign octave_o     = octave_q;
  assign note_o       = note_q;
  assign busy_o       = (state_q != IDLE);
  assign note_stb_o   = note_stb_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_rtttl_player.sv
// Bench for rtttl_player: directed and random songs compared against an event-level
// timeline derived from tick arithmetic (start edge, dur*TICK_DIV, fetch latency).
module tb_rtttl_player;

  localparam int TICK   = 4;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int DUR_W  = 6;

  typedef struct {
    int lbl;
    int on;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       loopEn = 1'b0;
  logic [3:0] octave;
  logic [3:0] note;
  logic       busy;
  logic       noteStb;
  logic       done;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int obsFetch = 0;
  int expFetch = 0;
  ev_t obsStb[$];
  ev_t expStb[$];
  int obsDone[$];
  int expDone[$];
  logic [13:0] romMem [256];

  rtttl_player_if #(.ADDR_W(ADDR_W), .DUR_W(DUR_W)) romIf ();

  rtttl_player #(
    .TICK_DIV(TICK),
    .ADDR_W(ADDR_W),
    .DEPTH(DEPTH),
    .DUR_W(DUR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start),
    .stop_i(stop),
    .pause_i(pause),
    .loop_en_i(loopEn),
    .rom(romIf),
    .octave_o(octave),
    .note_o(note),
    .busy_o(busy),
    .note_stb_o(noteStb),
    .done_o(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (romIf.rom_en) romIf.rom_data <= romMem[romIf.rom_addr];
  end

  // Each posedge gets a label; outputs seen 1 time unit later belong to that label.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (noteStb) obsStb.push_back('{cyc, int'({octave, note})});
      if (done) obsDone.push_back(cyc);
      if (romIf.rom_en) obsFetch++;
    end
  end

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic waitLabel(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  function automatic int shiftLbl(input int lbl, input int p, input int len);
    return (len > 0 && lbl >= p) ? lbl + len : lbl;
  endfunction

  // Ticks fall on edges s+k*TICK; a note loaded at edge L ends on its dur-th tick after L.
  task automatic buildExpected(input int s, input bit lp, input int horizon,
                               input int pStart, input int pLen);
    int addr;
    int t;
    int ld;
    int d;
    int fin;
    int firstTick;
    logic [13:0] e;
    expStb.delete();
    expDone.delete();
    addr = 0;
    t = s;
    expFetch = 1;
    for (int guard = 0; guard < 200; guard++) begin
      ld = t + 2;
      if (ld >= horizon) break;
      e = romMem[8'(addr)];
      d = int'(e[5:0]);
      if (d == 0) begin
        if (lp && addr != 0) begin
          addr = 0;
          t = ld;
          expFetch++;
          continue;
        end
        expDone.push_back(shiftLbl(ld, pStart, pLen));
        break;
      end
      expStb.push_back('{shiftLbl(ld, pStart, pLen), int'(e[13:6])});
      firstTick = s + ((ld - s) / TICK + 1) * TICK;
      fin = firstTick + (d - 1) * TICK;
      if (fin >= horizon) break;
      if (addr + 1 == DEPTH) begin
        if (lp && addr != 0) begin
          addr = 0;
          t = fin;
          expFetch++;
        end else begin
          expDone.push_back(shiftLbl(fin, pStart, pLen));
          break;
        end
      end else begin
        addr++;
        t = fin;
        expFetch++;
      end
    end
  endtask

  task automatic compareRun(input string tag);
    checkOutput({tag, ".stbCount"}, obsStb.size(), expStb.size());
    for (int i = 0; i < obsStb.size() && i < expStb.size(); i++) begin
      checkOutput({tag, ".stbCycle"}, obsStb[i].lbl, expStb[i].lbl);
      checkOutput({tag, ".stbNote"}, obsStb[i].on, expStb[i].on);
    end
    checkOutput({tag, ".doneCount"}, obsDone.size(), expDone.size());
    for (int i = 0; i < obsDone.size() && i < expDone.size(); i++) begin
      checkOutput({tag, ".doneCycle"}, obsDone[i], expDone[i]);
    end
    checkOutput({tag, ".fetchCount"}, obsFetch, expFetch);
  endtask

  // Start a song, optionally pause it pauseAt cycles into the first note, stop after window.
  task automatic applyStimulus(input string tag, input bit lp, input int window,
                               input int pauseAt, input int pauseLen, input logic [7:0] holdOn);
    int s;
    int pStart;
    int stopEdge;
    obsStb.delete();
    obsDone.delete();
    obsFetch = 0;
    loopEn = lp;
    s = cyc + 1;
    start = 1'b1;
    waitLabel(s);
    start = 1'b0;
    checkOutput({tag, ".busyAtFetch"}, longint'(busy), 1);
    checkOutput({tag, ".addrAtFetch"}, longint'(romIf.rom_addr), 0);
    pStart = s + 2 + pauseAt;
    if (pauseLen > 0) begin
      waitLabel(pStart - 1);
      pause = 1'b1;
      for (int i = 0; i < pauseLen; i++) begin
        waitLabel(pStart + i);
        checkOutput({tag, ".holdNote"}, longint'({octave, note}), longint'(holdOn));
        checkOutput({tag, ".holdBusy"}, longint'(busy), 1);
      end
      pause = 1'b0;
    end
    stopEdge = s + window;
    waitLabel(stopEdge - 1);
    stop = 1'b1;
    waitLabel(stopEdge);
    stop = 1'b0;
    checkOutput({tag, ".busyAfterStop"}, longint'(busy), 0);
    checkOutput({tag, ".noteAfterStop"}, longint'({octave, note}), 0);
    waitLabel(stopEdge + 3);
    buildExpected(s, lp, stopEdge - pauseLen, pStart, pauseLen);
    compareRun(tag);
  endtask

  task automatic loadDirected();
    romMem[0] = {4'd5, 4'd6, 6'd2};
    romMem[1] = {4'd4, 4'd12, 6'd1};
    romMem[2] = {4'd5, 4'd4, 6'd3};
    romMem[3] = 14'h0;
  endtask

  initial begin
    int s;
    int endAt;
    for (int i = 0; i < 256; i++) romMem[i] = 14'h0;
    romIf.rom_data = '0;

    waitLabel(3);
    checkOutput("reset.busy", longint'(busy), 0);
    checkOutput("reset.octNote", longint'({octave, note}), 0);
    checkOutput("reset.romEn", longint'(romIf.rom_en), 0);
    checkOutput("reset.romAddr", longint'(romIf.rom_addr), 0);
    checkOutput("reset.stb", longint'(noteStb), 0);
    checkOutput("reset.done", longint'(done), 0);
    rst = 1'b0;
    waitLabel(cyc + 2);

    loadDirected();
    applyStimulus("song", 1'b0, 50, 0, 0, 8'h00);
    applyStimulus("loop", 1'b1, 150, 0, 0, 8'h00);
    applyStimulus("pause", 1'b0, 60, 3, 10, 8'h56);
    applyStimulus("stop", 1'b0, 11, 0, 0, 8'h00);
    waitLabel(cyc + 1);
    applyStimulus("replay", 1'b0, 50, 0, 0, 8'h00);

    // Asynchronous reset in the middle of the first note, with start held high.
    loopEn = 1'b0;
    s = cyc + 1;
    start = 1'b1;
    waitLabel(s);
    start = 1'b0;
    waitLabel(s + 5);
    @(posedge clk);
    #2;
    rst = 1'b1;
    start = 1'b1;
    #1;
    checkOutput("asyncRst.busy", longint'(busy), 0);
    checkOutput("asyncRst.octNote", longint'({octave, note}), 0);
    checkOutput("asyncRst.romEn", longint'(romIf.rom_en), 0);
    checkOutput("asyncRst.romAddr", longint'(romIf.rom_addr), 0);
    waitLabel(cyc + 3);
    checkOutput("asyncRst.held", longint'(busy), 0);
    start = 1'b0;
    rst = 1'b0;
    waitLabel(cyc + 3);
    checkOutput("asyncRst.idleAfter", longint'(busy), 0);

    romMem[0] = 14'h0;
    applyStimulus("endAt0", 1'b1, 20, 0, 0, 8'h00);

    for (int run = 0; run < 10; run++) begin
      for (int a = 0; a < DEPTH; a++) begin
        romMem[a] = {4'($urandom_range(1, 8)), 4'($urandom_range(0, 12)),
                     6'($urandom_range(1, 3))};
      end
      endAt = int'($urandom_range(0, 4));
      if (endAt < DEPTH) romMem[endAt][5:0] = 6'd0;
      waitLabel(cyc + int'($urandom_range(1, 4)));
      applyStimulus($sformatf("rand%0d", run), 1'($urandom_range(0, 1)),
                    int'($urandom_range(20, 140)), 0, 0, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
